data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter.sv | 149 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter (CPU = 0, DMA/debug = 1) sequencing one access at a time to a memory manager.
// Default build is round-robin; define DMM_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module data_memory_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              in_rst_n,
  input  logic [1:0]        in_req,
  input  logic [1:0]        in_we,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [DATA_W-1:0] in_wdata0,
  input  logic [DATA_W-1:0] in_wdata1,
  output logic [1:0]        out_ack,
  output logic [DATA_W-1:0] out_rdata,
  output logic [1:0]        out_grant,
  output logic              out_busy,
  output logic              out_mem_addr_write_en,
  output logic              out_mem_read_en,
  output logic              out_mem_write_en,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [DATA_W-1:0] out_mem_wdata,
  input  logic [DATA_W-1:0] in_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                win1;

`ifdef DMM_ARB_FIXED_PRIO_EN
  always_comb begin
    win1 = ~in_req[0];
  end
`else
  // last_q is 1 when requester 1 owned the previous grant, so requester 0 wins the next tie.
  logic last_q, last_d;

  always_comb begin
    win1 = in_req[1] & (~in_req[0] | ~last_q);
  end

  always_ff @(posedge clk) begin
    if (!in_rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && in_req != 2'b00) begin
      last_d = win1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!in_rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Operands are captured only when leaving IDLE, so later input changes cannot disturb a transaction.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (in_req != 2'b00) begin
          state_d = S_ADDR;
          grant_d = win1 ? 2'b10 : 2'b01;
          we_d    = win1 ? in_we[1] : in_we[0];
          addr_d  = win1 ? in_addr1 : in_addr0;
          wdata_d = win1 ? in_wdata1 : in_wdata0;
        end
      end
      S_ADDR: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (!we_q) begin
          rdata_d = in_mem_rdata;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    out_ack               = 2'b00;
    out_mem_addr_write_en = 1'b0;
    out_mem_read_en       = 1'b0;
    out_mem_write_en      = 1'b0;
    case (state_q)
      S_ADDR:   out_mem_addr_write_en = 1'b1;
      S_ACCESS: begin
        out_mem_read_en  = ~we_q;
        out_mem_write_en = we_q;
      end
      S_DONE:   out_ack = grant_q;
      default:  ;
    endcase
  end

  // Address and write data track the latched operands, so they hold between transactions.
  assign out_grant     = grant_q;
  assign out_busy      = (state_q != S_IDLE);
  assign out_mem_addr  = addr_q;
  assign out_mem_wdata = wdata_q;
  assign out_rdata     = rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model (winner choice, last read data, latched operands).
module tb_data_memory_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk;
  logic          in_rst_n;
  logic [1:0]    in_req;
  logic [1:0]    in_we;
  logic [AW-1:0] in_addr0, in_addr1;
  logic [DW-1:0] in_wdata0, in_wdata1;
  logic [1:0]    out_ack;
  logic [DW-1:0] out_rdata;
  logic [1:0]    out_grant;
  logic          out_busy;
  logic          out_mem_addr_write_en, out_mem_read_en, out_mem_write_en;
  logic [AW-1:0] out_mem_addr;
  logic [DW-1:0] out_mem_wdata;
  logic [DW-1:0] in_mem_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            last_win;
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  int            txn_no = 0;

  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                   (clk),
    .in_rst_n              (in_rst_n),
    .in_req                (in_req),
    .in_we                 (in_we),
    .in_addr0              (in_addr0),
    .in_addr1              (in_addr1),
    .in_wdata0             (in_wdata0),
    .in_wdata1             (in_wdata1),
    .out_ack               (out_ack),
    .out_rdata             (out_rdata),
    .out_grant             (out_grant),
    .out_busy              (out_busy),
    .out_mem_addr_write_en (out_mem_addr_write_en),
    .out_mem_read_en       (out_mem_read_en),
    .out_mem_write_en      (out_mem_write_en),
    .out_mem_addr          (out_mem_addr),
    .out_mem_wdata         (out_mem_wdata),
    .in_mem_rdata          (in_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {grant, ack, busy, addr_write_en, read_en, write_en}
  function automatic logic [7:0] status();
    return {out_grant, out_ack, out_busy, out_mem_addr_write_en, out_mem_read_en, out_mem_write_en};
  endfunction

  function automatic int pick(input logic [1:0] r);
`ifdef DMM_ARB_FIXED_PRIO_EN
    return r[0] ? 0 : 1;
`else
    if (r == 2'b11) return (last_win == 1) ? 0 : 1;
    return r[0] ? 0 : 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_win  = 1;
    exp_rdata = '0;
    exp_addr  = '0;
    exp_wdata = '0;
  endtask

  task automatic test_reset();
    in_rst_n = 1'b0;
    tick();
    tick();
    in_rst_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if (status() !== 8'h00) begin
      errors++;
      $display("FAIL reset_status: got %b want %b", status(), 8'h00);
    end
    checks++;
    if ({out_mem_addr, out_mem_wdata, out_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr %h wdata %h rdata %h want all 0", out_mem_addr, out_mem_wdata, out_rdata);
    end
  endtask

  task automatic test_single_read();
    in_we = 2'b00; in_addr0 = 10'h3FE; in_wdata0 = 8'h3C; in_req = 2'b01;
    tick();
    checks++;
    if (status() !== 8'b01_00_1_100 || out_mem_addr !== 10'h3FE) begin
      errors++;
      $display("FAIL read_addr_phase: got %b addr %h want %b addr 3fe", status(), out_mem_addr, 8'b01_00_1_100);
    end
    tick();
    in_mem_rdata = 8'h05;
    checks++;
    if (status() !== 8'b01_00_1_010) begin
      errors++;
      $display("FAIL read_access_phase: got %b want %b", status(), 8'b01_00_1_010);
    end
    tick();
    checks++;
    if (out_ack !== 2'b01 || out_rdata !== 8'h05 || out_busy !== 1'b1) begin
      errors++;
      $display("FAIL read_done: got ack %b rdata %h busy %b want ack 01 rdata 05 busy 1", out_ack, out_rdata, out_busy);
    end
    in_req = 2'b00;
    tick();
    checks++;
    if (status() !== 8'h00) begin
      errors++;
      $display("FAIL read_back_idle: got %b want %b", status(), 8'h00);
    end
    last_win = 0; exp_rdata = 8'h05; exp_addr = 10'h3FE; exp_wdata = 8'h3C;
    $display("txn %0d: single read req0 addr 3fe rdata %h", txn_no++, out_rdata);
  endtask

  task automatic test_write();
    in_we = 2'b10; in_addr1 = 10'h012; in_wdata1 = 8'hA5; in_req = 2'b10;
    tick();
    checks++;
    if (status() !== 8'b10_00_1_100 || out_mem_addr !== 10'h012) begin
      errors++;
      $display("FAIL write_addr_phase: got %b addr %h want %b addr 012", status(), out_mem_addr, 8'b10_00_1_100);
    end
    tick();
    in_mem_rdata = 8'h77;
    checks++;
    if (status() !== 8'b10_00_1_001 || out_mem_wdata !== 8'hA5) begin
      errors++;
      $display("FAIL write_access_phase: got %b wdata %h want %b wdata a5", status(), out_mem_wdata, 8'b10_00_1_001);
    end
    tick();
    checks++;
    if (out_ack !== 2'b10 || out_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL write_done: got ack %b rdata %h want ack 10 rdata %h", out_ack, out_rdata, exp_rdata);
    end
    in_req = 2'b00;
    tick();
    last_win = 1; exp_addr = 10'h012; exp_wdata = 8'hA5;
    $display("txn %0d: write req1 addr 012 wdata a5", txn_no++);
  endtask

  task automatic test_round_robin();
    int w;
    logic [1:0] g;
    in_we = 2'b00; in_addr0 = 10'h100; in_addr1 = 10'h200;
    in_wdata0 = 8'h11; in_wdata1 = 8'h22; in_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      w = pick(2'b11);
      g = (w == 0) ? 2'b01 : 2'b10;
      tick();
      checks++;
      if (out_grant !== g) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", i, out_grant, g);
      end
      tick();
      in_mem_rdata = 8'(8'h40 + i);
      tick();
      checks++;
      if (out_ack !== g || out_rdata !== 8'(8'h40 + i)) begin
        errors++;
        $display("FAIL rr_done%0d: got ack %b rdata %h want ack %b rdata %h", i, out_ack, out_rdata, g, 8'(8'h40 + i));
      end
      last_win = w; exp_rdata = 8'(8'h40 + i);
      exp_addr = (w == 0) ? 10'h100 : 10'h200;
      exp_wdata = (w == 0) ? 8'h11 : 8'h22;
      tick();
      $display("txn %0d: both requesting, grant %b", txn_no++, g);
    end
    in_req = 2'b00;
    tick();
  endtask

  task automatic test_drop_during_access();
    in_we = 2'b00; in_addr0 = 10'h055; in_wdata0 = 8'h99; in_req = 2'b01;
    tick();
    tick();
    in_req = 2'b00;
    in_mem_rdata = 8'hC3;
    tick();
    checks++;
    if (out_ack !== 2'b01 || out_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL drop_ack: got ack %b rdata %h want ack 01 rdata c3", out_ack, out_rdata);
    end
    tick();
    checks++;
    if (status() !== 8'h00) begin
      errors++;
      $display("FAIL drop_idle: got %b want %b", status(), 8'h00);
    end
    tick();
    checks++;
    if (status() !== 8'h00) begin
      errors++;
      $display("FAIL drop_no_second: got %b want %b", status(), 8'h00);
    end
    last_win = 0; exp_rdata = 8'hC3; exp_addr = 10'h055; exp_wdata = 8'h99;
    $display("txn %0d: req0 dropped during access, acked", txn_no++);
  endtask

  task automatic test_reset_mid();
    in_we = 2'b00; in_addr1 = 10'h2AA; in_wdata1 = 8'h5A; in_req = 2'b10;
    tick();
    tick();
    in_rst_n = 1'b0;
    tick();
    model_reset();
    checks++;
    if (status() !== 8'h00 || {out_mem_addr, out_mem_wdata, out_rdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b addr %h wdata %h rdata %h want all 0",
               status(), out_mem_addr, out_mem_wdata, out_rdata);
    end
    in_rst_n = 1'b1;
    tick();
    checks++;
    if (status() !== 8'b10_00_1_100 || out_mem_addr !== 10'h2AA) begin
      errors++;
      $display("FAIL rst_mid_regrant: got %b addr %h want %b addr 2aa", status(), out_mem_addr, 8'b10_00_1_100);
    end
    tick();
    in_mem_rdata = 8'hE1;
    tick();
    checks++;
    if (out_ack !== 2'b10 || out_rdata !== 8'hE1) begin
      errors++;
      $display("FAIL rst_mid_served: got ack %b rdata %h want ack 10 rdata e1", out_ack, out_rdata);
    end
    in_req = 2'b00;
    tick();
    last_win = 1; exp_rdata = 8'hE1; exp_addr = 10'h2AA; exp_wdata = 8'h5A;
    $display("txn %0d: reset during access, req1 served after", txn_no++);
  endtask

  task automatic test_random();
    logic [1:0]    req, g;
    int            w;
    logic          we_w;
    logic [AW-1:0] a_w;
    logic [DW-1:0] d_w, rd;
    for (int n = 0; n < 40; n++) begin
      req = 2'($urandom_range(0, 3));
      in_we = 2'($urandom_range(0, 3));
      in_addr0 = AW'($urandom); in_addr1 = AW'($urandom);
      in_wdata0 = DW'($urandom); in_wdata1 = DW'($urandom);
      in_req = req;
      if (req == 2'b00) begin
        tick();
        checks++;
        if (status() !== 8'h00 || out_mem_addr !== exp_addr || out_mem_wdata !== exp_wdata) begin
          errors++;
          $display("FAIL rand_idle%0d: got %b addr %h wdata %h want 0 addr %h wdata %h",
                   n, status(), out_mem_addr, out_mem_wdata, exp_addr, exp_wdata);
        end
        continue;
      end
      w    = pick(req);
      g    = (w == 0) ? 2'b01 : 2'b10;
      we_w = in_we[w];
      a_w  = (w == 0) ? in_addr0 : in_addr1;
      d_w  = (w == 0) ? in_wdata0 : in_wdata1;
      tick();
      checks++;
      if (status() !== {g, 2'b00, 4'b1100} || out_mem_addr !== a_w) begin
        errors++;
        $display("FAIL rand_addr%0d: got %b addr %h want %b addr %h", n, status(), out_mem_addr, {g, 2'b00, 4'b1100}, a_w);
      end
      // Operands may change freely once granted
      in_req = 2'($urandom_range(0, 3)); in_we = 2'($urandom_range(0, 3));
      in_addr0 = AW'($urandom); in_addr1 = AW'($urandom);
      in_wdata0 = DW'($urandom); in_wdata1 = DW'($urandom);
      tick();
      rd = DW'($urandom);
      in_mem_rdata = rd;
      checks++;
      if (status() !== {g, 2'b00, 1'b1, 1'b0, ~we_w, we_w} || out_mem_wdata !== d_w) begin
        errors++;
        $display("FAIL rand_access%0d: got %b wdata %h want %b wdata %h",
                 n, status(), out_mem_wdata, {g, 2'b00, 1'b1, 1'b0, ~we_w, we_w}, d_w);
      end
      tick();
      if (!we_w) exp_rdata = rd;
      checks++;
      if (out_ack !== g || out_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rand_done%0d: got ack %b rdata %h want ack %b rdata %h", n, out_ack, out_rdata, g, exp_rdata);
      end
      in_req = 2'b00;
      tick();
      last_win = w; exp_addr = a_w; exp_wdata = d_w;
      $display("txn %0d: req %b grant %b we %b addr %h", txn_no++, req, g, we_w, a_w);
    end
  endtask

  initial begin
    in_rst_n = 1'b0; in_req = 2'b00; in_we = 2'b00;
    in_addr0 = '0; in_addr1 = '0; in_wdata0 = '0; in_wdata1 = '0; in_mem_rdata = '0;
    model_reset();
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_drop_during_access();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
